// File: rtl/memory_responder.sv
// Pipelined data-memory responder: single-word reads/writes and aligned line bursts,
// with read data returned in order after a fixed LATENCY.
module memory_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic                  req_burst,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_data,
  output logic                  resp_valid,
  output logic [15:0]           resp_data,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  resp_last,
  output logic                  busy
);

  localparam int unsigned WW    = ADDR_WIDTH - 1;
  localparam int unsigned LB    = $clog2(LINE_WORDS);
  localparam int unsigned DEPTH = 2 ** WW;

  typedef enum logic {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic [LB-1:0]    cnt_q, cnt_d;
  logic [WW-LB-1:0] line_q, line_d;

  logic [15:0]         mem [DEPTH];
  logic                accept, do_write, issue_valid, issue_last;
  logic [WW-1:0]       req_word, issue_word;
  logic [LATENCY-1:0]  pipe_valid, pipe_last;
  logic [15:0]         pipe_data [LATENCY];
  logic [WW-1:0]       pipe_word [LATENCY];
  logic                unused_addr0;

  assign unused_addr0 = req_addr[0];
  assign req_word     = req_addr[ADDR_WIDTH-1:1];
  // Gated by rst_n so nothing is accepted (or written) while reset is held.
  assign req_ready    = rst_n & (state_q == StIdle);
  assign accept       = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !req_wr && req_burst) begin
          state_d = StBurst;
          cnt_d   = LB'(1);
          line_d  = req_word[WW-1:LB];
        end
      end
      StBurst: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LB'(LINE_WORDS - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    do_write    = 1'b0;
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    issue_word  = req_word;
    unique case (state_q)
      StIdle: begin
        do_write    = accept & req_wr;
        issue_valid = accept & ~req_wr;
        issue_last  = ~req_burst;
        if (req_burst) issue_word = {req_word[WW-1:LB], {LB{1'b0}}};
      end
      StBurst: begin
        issue_valid = 1'b1;
        issue_word  = {line_q, cnt_q};
        issue_last  = (cnt_q == LB'(LINE_WORDS - 1));
      end
      default: ;
    endcase
  end

  // Storage is deliberately not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (do_write) mem[req_word] <= req_data;
  end

  // Payload only advances with a valid entry, so the output stage holds its last data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data[i] <= '0;
        pipe_word[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= issue_valid;
      if (issue_valid) begin
        pipe_data[0] <= mem[issue_word];
        pipe_word[0] <= issue_word;
        pipe_last[0] <= issue_last;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
          pipe_word[i] <= pipe_word[i-1];
          pipe_last[i] <= pipe_last[i-1];
        end
      end
    end
  end

  assign resp_valid = pipe_valid[LATENCY-1];
  assign resp_data  = pipe_data[LATENCY-1];
  assign resp_addr  = {pipe_word[LATENCY-1], 1'b0};
  assign resp_last  = pipe_valid[LATENCY-1] & pipe_last[LATENCY-1];
  assign busy       = (state_q == StBurst) | (|pipe_valid);

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed table, hand sequences and random traffic checked
// against a queue-based reference model; a second LATENCY=1 instance covers the short pipe.
module tb_memory_responder;

  localparam int L  = 4;
  localparam int LW = 8;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic [15:0] addr;
    bit          last;
  } resp_t;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_data;
    logic [15:0] exp_addr;
  } vec_t;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_wr, req_burst;
  logic [15:0] req_addr, req_data;
  logic        resp_valid, resp_last, busy;
  logic [15:0] resp_data, resp_addr;

  logic        l1_valid, l1_ready, l1_wr, l1_burst;
  logic [15:0] l1_addr, l1_data;
  logic        l1_rvalid, l1_rlast, l1_busy;
  logic [15:0] l1_rdata, l1_raddr;

  logic [15:0] mem_m [32768];
  resp_t       q[$];
  int          c, ready_at;
  logic [15:0] hold_data, hold_addr;
  int          n_vec, n_err;

  memory_responder #(.LATENCY(L), .LINE_WORDS(LW), .ADDR_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_burst(req_burst),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_addr(resp_addr),
    .resp_last(resp_last), .busy(busy)
  );

  memory_responder #(.LATENCY(1), .LINE_WORDS(LW), .ADDR_WIDTH(16)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(l1_valid), .req_ready(l1_ready), .req_wr(l1_wr), .req_burst(l1_burst),
    .req_addr(l1_addr), .req_data(l1_data),
    .resp_valid(l1_rvalid), .resp_data(l1_rdata), .resp_addr(l1_raddr),
    .resp_last(l1_rlast), .busy(l1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end, got running want finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, c, act, exp);
    end
  endtask

  // Compare every output against the model for the current cycle.
  task automatic check();
    bit    exp_valid, exp_busy;
    resp_t e;
    if (!rst_n) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", resp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_last", resp_last, 0);
      chk("rst_data", resp_data, 0);
      return;
    end
    exp_valid = (q.size() > 0) && (q[0].due == c);
    exp_busy  = (c < ready_at) || ((q.size() > 0) && (q[0].due - L + 1 <= c));
    chk("req_ready", req_ready, (c >= ready_at) ? 1 : 0);
    chk("busy", busy, exp_busy);
    chk("resp_valid", resp_valid, exp_valid);
    if (exp_valid) begin
      e = q.pop_front();
      chk("resp_data", resp_data, e.data);
      chk("resp_addr", resp_addr, e.addr);
      chk("resp_last", resp_last, e.last);
      hold_data = e.data;
      hold_addr = e.addr;
    end else begin
      chk("hold_data", resp_data, hold_data);
      chk("hold_addr", resp_addr, hold_addr);
      chk("idle_last", resp_last, 0);
    end
  endtask

  // Drive one cycle of main-port stimulus, update the model, then check at the next negedge.
  task automatic step(input bit v, input bit wr, input bit bu, input logic [15:0] a,
                      input logic [15:0] d);
    int w, base;
    req_valid = v;
    req_wr    = wr;
    req_burst = bu;
    req_addr  = a;
    req_data  = d;
    if (v && rst_n && (c >= ready_at)) begin
      w = int'(a[15:1]);
      if (wr) begin
        mem_m[w] = d;
      end else if (!bu) begin
        q.push_back('{c + L, mem_m[w], 16'(w * 2), 1'b1});
      end else begin
        base = w & ~(LW - 1);
        for (int i = 0; i < LW; i++)
          q.push_back('{c + L + i, mem_m[base+i], 16'((base + i) * 2), (i == LW - 1)});
        ready_at = c + LW;
      end
    end
    @(negedge clk);
    c++;
    check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 16'h0);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 16'h0011, 16'h0000, 16'hBEEF, 16'h0010};
    tbl[2] = '{1'b1, 16'h0000, 16'h1234, 16'h0000, 16'h0000};
    tbl[3] = '{1'b1, 16'h0002, 16'h5678, 16'h0000, 16'h0000};
    tbl[4] = '{1'b1, 16'h0004, 16'h9ABC, 16'h0000, 16'h0000};
    tbl[5] = '{1'b1, 16'h0020, 16'h1111, 16'h0000, 16'h0000};
    tbl[6] = '{1'b0, 16'h0005, 16'h0000, 16'h9ABC, 16'h0004};

    n_vec = 0; n_err = 0; c = 0; ready_at = 0;
    hold_data = '0; hold_addr = '0;
    rst_n = 1'b0;
    req_valid = 0; req_wr = 0; req_burst = 0; req_addr = '0; req_data = '0;
    l1_valid = 0; l1_wr = 0; l1_burst = 0; l1_addr = '0; l1_data = '0;
    repeat (3) @(negedge clk);
    check();
    chk("l1_rst_ready", l1_ready, 0);
    chk("l1_rst_busy", l1_busy, 0);
    rst_n = 1'b1;

    // LATENCY=1 instance: burst+write is a single write with no response.
    l1_valid = 1; l1_wr = 1; l1_burst = 1; l1_addr = 16'h0040; l1_data = 16'h0A0A;
    idle(1);
    l1_wr = 0; l1_burst = 0; l1_addr = 16'h0041;
    chk("l1_no_wr_resp", l1_rvalid, 0);
    chk("l1_ready_after_wr", l1_ready, 1);
    idle(1);
    chk("l1_rvalid", l1_rvalid, 1);
    chk("l1_rdata", l1_rdata, 16'h0A0A);
    chk("l1_raddr", l1_raddr, 16'h0040);
    chk("l1_rlast", l1_rlast, 1);
    chk("l1_busy", l1_busy, 1);
    l1_valid = 0;
    idle(1);
    chk("l1_rvalid_drop", l1_rvalid, 0);
    chk("l1_hold", l1_rdata, 16'h0A0A);
    chk("l1_busy_drop", l1_busy, 0);

    // Directed table; each read is followed by L-1 idles so its response is visible.
    for (int i = 0; i < 7; i++) begin
      step(1, tbl[i].wr, 0, tbl[i].addr, tbl[i].data);
      if (!tbl[i].wr) begin
        idle(L - 1);
        chk("tbl_valid", resp_valid, 1);
        chk("tbl_data", resp_data, tbl[i].exp_data);
        chk("tbl_addr", resp_addr, tbl[i].exp_addr);
        chk("tbl_last", resp_last, 1);
      end
    end
    idle(2);

    // Back-to-back single reads.
    step(1, 0, 0, 16'h0000, 16'h0);
    step(1, 0, 0, 16'h0002, 16'h0);
    step(1, 0, 0, 16'h0004, 16'h0);
    idle(L + 1);

    // Burst from mid-line with a request held through BURST.
    for (int i = 0; i < LW; i++) step(1, 1, 0, 16'(16'h0030 + 2 * i), 16'(16'hC000 + i));
    step(1, 0, 1, 16'h0036, 16'h0);
    for (int i = 0; i < LW; i++) step(1, 0, 0, 16'h0010, 16'h0);
    idle(L + LW);

    // Read-then-write hazard on 0x0020 (holds 0x1111).
    step(1, 0, 0, 16'h0020, 16'h0);
    step(1, 1, 0, 16'h0020, 16'h2222);
    idle(L - 2);
    chk("hazard_valid", resp_valid, 1);
    chk("hazard_old", resp_data, 16'h1111);
    step(1, 0, 0, 16'h0020, 16'h0);
    idle(L - 1);
    chk("hazard_new", resp_data, 16'h2222);
    idle(2);

    // Random traffic over a preloaded window.
    for (int i = 0; i < 64; i++) step(1, 1, 0, 16'(i * 2), 16'($urandom));
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0),
           16'(($urandom_range(0, 63) << 1) | $urandom_range(0, 1)), 16'($urandom));
    idle(L + LW);

    // Reset mid-burst: in-flight words are discarded, array contents kept.
    step(1, 0, 1, 16'h0010, 16'h0);
    idle(2);
    rst_n = 1'b0;
    q.delete();
    hold_data = '0;
    hold_addr = '0;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_last", resp_last, 0);
    idle(2);
    rst_n = 1'b1;
    ready_at = c;
    idle(12);
    step(1, 0, 1, 16'h0010, 16'h0);
    idle(L + LW);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
